// File: rtl/fma_issue_arbiter_if.sv
// rtl/fma_issue_arbiter_if.sv - requester, FMA and result signal bundle for fma_issue_arbiter
interface fma_issue_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int WID     = 64,
    parameter int LATENCY = 27
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LATENCY + 1);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*WID-1:0] req_a;
    logic [NREQ*WID-1:0] req_b;
    logic [NREQ*WID-1:0] req_c;
    logic [NREQ*3-1:0]   req_rm;
    logic                fma_ce;
    logic [2:0]          fma_rm;
    logic [WID-1:0]      fma_a;
    logic [WID-1:0]      fma_b;
    logic [WID-1:0]      fma_c;
    logic [WID-1:0]      fma_o;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [WID-1:0]      res_o;
    logic                res_ready;
    logic [CW-1:0]       inflight;

    // Environment side: requesters, the FMA core and the result consumer
    modport master (
        output req_valid, req_a, req_b, req_c, req_rm, fma_o, res_ready,
        input  req_ready, fma_ce, fma_rm, fma_a, fma_b, fma_c,
        input  res_valid, res_id, res_o, inflight
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_c, req_rm, fma_o, res_ready,
        output req_ready, fma_ce, fma_rm, fma_a, fma_b, fma_c,
        output res_valid, res_id, res_o, inflight
    );
endinterface

// File: rtl/fma_issue_arbiter.sv
// rtl/fma_issue_arbiter.sv - round-robin issue of NREQ requesters into one pipelined FMA with tag tracking
module fma_issue_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 27,
    parameter int WID     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    fma_issue_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LATENCY + 1);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     sel;
    logic               gnt_any;
    logic               gnt;
    logic               out_valid;
    logic               ce;
    logic               consume;
    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];
    logic [CW-1:0]      inflight_q;

    // Output stage of the tag pipeline; reset masks any valid bit still sitting there
    always_comb begin
        out_valid = tag_v[LATENCY-1] & ~rst;
        ce        = ~(out_valid & ~bus.res_ready);
        consume   = out_valid & bus.res_ready;
    end

    // Round-robin search starting at ptr; scanning downward lets the closest slot win
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (bus.req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
        gnt = gnt_any & ce & ~rst;
        sel = gnt ? gnt_idx : ptr;
    end

    // Grant strobe, FMA operand mux and result outputs
    always_comb begin
        bus.req_ready = '0;
        if (gnt) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
        bus.fma_ce    = ce;
        bus.fma_a     = bus.req_a[sel*WID +: WID];
        bus.fma_b     = bus.req_b[sel*WID +: WID];
        bus.fma_c     = bus.req_c[sel*WID +: WID];
        bus.fma_rm    = bus.req_rm[sel*3 +: 3];
        bus.res_valid = out_valid;
        bus.res_id    = tag_id[LATENCY-1];
        bus.res_o     = bus.fma_o;
        bus.inflight  = inflight_q;
    end

    // Pointer moves just past the winner; it holds on idle and stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt) begin
            ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    // Tag pipeline advances in lockstep with the FMA clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
        end else if (ce) begin
            tag_v     <= {tag_v[LATENCY-2:0], gnt};
            tag_id[0] <= gnt_idx;
            for (int s = 1; s < LATENCY; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // Count of valid tags: up on issue, down on consume, unchanged when both or neither
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            case ({gnt, consume})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end
endmodule
